// File: rtl/video_pkg.sv
// Shared definitions for the pixel-stream blocks: default widths and the
// state encodings of the frame source fetch and emit machines.
package video_pkg;

    localparam int PIX_W = 8;
    localparam int DIM_W = 8;

    typedef enum logic [1:0] {
        F_IDLE,
        F_FETCH,
        F_WAIT_BANK
    } fetch_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_EMIT,
        E_GAP
    } emit_state_t;

endpackage

// File: rtl/line_buffer.sv
// Ping-pong line store: two banks with a shared write port (memory fetch side),
// a registered read port (stream side) and one full flag per bank.
module line_buffer #(
    parameter int PIX_W = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_nReset,
    input  logic             i_wrEn,
    input  logic             i_wrBank,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [PIX_W-1:0] i_wrData,
    input  logic             i_setFull,
    input  logic             i_rdEn,
    input  logic             i_rdBank,
    input  logic [AW-1:0]    i_rdAddr,
    input  logic             i_clrFull,
    output logic [PIX_W-1:0] o_rdData,
    output logic [1:0]       o_full
);

    logic [PIX_W-1:0] r_bank0 [DEPTH];
    logic [PIX_W-1:0] r_bank1 [DEPTH];
    logic [PIX_W-1:0] r_rdData;
    logic [1:0]       r_full;

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            if (i_wrBank) begin
                r_bank1[i_wrAddr] <= i_wrData;
            end else begin
                r_bank0[i_wrAddr] <= i_wrData;
            end
        end
    end

    // The read register returns to zero whenever no read is issued, so the
    // stream carries 0 outside active lines without an extra output mux.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= i_rdBank ? r_bank1[i_rdAddr] : r_bank0[i_rdAddr];
        end else begin
            r_rdData <= '0;
        end
    end

    // Set and clear always target different banks: the writer only fills an
    // empty bank and the reader only drains a full one.
    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            r_full <= 2'b00;
        end else begin
            if (i_setFull) begin
                r_full[i_wrBank] <= 1'b1;
            end
            if (i_clrFull) begin
                r_full[i_rdBank] <= 1'b0;
            end
        end
    end

    assign o_rdData = r_rdData;
    assign o_full   = r_full;

endmodule

// File: rtl/frame_source.sv
// Pixel-stream source: fetches a Width x Height frame from a word-per-pixel
// memory port into ping-pong line banks and streams it with frame/line strobes.
module frame_source #(
    parameter int PIX_W  = video_pkg::PIX_W,
    parameter int DIM_W  = video_pkg::DIM_W,
    parameter int ADDR_W = 16,
    parameter int MAX_W  = 256
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Start,
    input  logic [DIM_W-1:0]  Width,
    input  logic [DIM_W-1:0]  Height,
    input  logic [ADDR_W-1:0] BaseAddr,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [PIX_W-1:0]  MemData,
    output logic [PIX_W-1:0]  PixelOut,
    output logic              FrameOut,
    output logic              LineOut,
    output logic              Busy
);

    import video_pkg::*;

    fetch_state_t      r_fState, w_fNext;
    emit_state_t       r_eState, w_eNext;

    logic [DIM_W-1:0]  r_width, r_height;
    logic [ADDR_W-1:0] r_addr;
    logic [DIM_W-1:0]  r_fx, r_fy, r_ex, r_ey;
    logic              r_fBank, r_eBank;
    logic              r_busy, r_lastOut, r_frameOut, r_lineOut;

    logic              w_start, w_hs;
    logic              w_fLastX, w_fLastY, w_eLastX, w_eLastY;
    logic              w_rdEn, w_clrFull;
    logic [1:0]        w_full;
    logic [PIX_W-1:0]  w_rdData;

    assign w_start  = Start && !r_busy && (Width != '0) && (Height != '0);
    assign w_hs     = (r_fState == F_FETCH) && MemAck;
    assign w_fLastX = (r_fx == r_width - DIM_W'(1));
    assign w_fLastY = (r_fy == r_height - DIM_W'(1));
    assign w_eLastX = (r_ex == r_width - DIM_W'(1));
    assign w_eLastY = (r_ey == r_height - DIM_W'(1));

    always_comb begin
        w_fNext = r_fState;
        case (r_fState)
            F_IDLE: begin
                if (w_start) begin
                    w_fNext = F_FETCH;
                end
            end
            F_FETCH: begin
                if (w_hs && w_fLastX) begin
                    if (w_fLastY) begin
                        w_fNext = F_IDLE;
                    end else if (w_full[~r_fBank]) begin
                        w_fNext = F_WAIT_BANK;
                    end else begin
                        w_fNext = F_FETCH;
                    end
                end
            end
            F_WAIT_BANK: begin
                if (!w_full[r_fBank]) begin
                    w_fNext = F_FETCH;
                end
            end
            default: w_fNext = F_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_fState <= F_IDLE;
            r_width  <= '0;
            r_height <= '0;
            r_addr   <= '0;
            r_fx     <= '0;
            r_fy     <= '0;
            r_fBank  <= 1'b0;
        end else begin
            r_fState <= w_fNext;
            if (w_start) begin
                r_width  <= Width;
                r_height <= Height;
                r_addr   <= BaseAddr;
                r_fx     <= '0;
                r_fy     <= '0;
                r_fBank  <= 1'b0;
            end else if (w_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (w_fLastX) begin
                    r_fx    <= '0;
                    r_fy    <= r_fy + DIM_W'(1);
                    r_fBank <= ~r_fBank;
                end else begin
                    r_fx <= r_fx + DIM_W'(1);
                end
            end
        end
    end

    // A line is only emitted once its bank is complete, so a memory stall can
    // delay the start of a line but never open a hole inside one.
    always_comb begin
        w_eNext   = r_eState;
        w_rdEn    = 1'b0;
        w_clrFull = 1'b0;
        case (r_eState)
            E_IDLE: begin
                if (w_full[r_eBank]) begin
                    w_eNext = E_EMIT;
                end
            end
            E_EMIT: begin
                w_rdEn = 1'b1;
                if (w_eLastX) begin
                    w_clrFull = 1'b1;
                    w_eNext   = w_eLastY ? E_IDLE : E_GAP;
                end
            end
            E_GAP: begin
                w_eNext = w_full[r_eBank] ? E_EMIT : E_IDLE;
            end
            default: w_eNext = E_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_eState   <= E_IDLE;
            r_ex       <= '0;
            r_ey       <= '0;
            r_eBank    <= 1'b0;
            r_frameOut <= 1'b0;
            r_lineOut  <= 1'b0;
            r_lastOut  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_eState   <= w_eNext;
            r_frameOut <= w_rdEn && (r_ex == '0) && (r_ey == '0);
            r_lineOut  <= w_rdEn && (r_ex == '0) && (r_ey != '0);
            r_lastOut  <= w_rdEn && w_eLastX && w_eLastY;
            if (w_start) begin
                r_ex    <= '0;
                r_ey    <= '0;
                r_eBank <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                if (r_lastOut) begin
                    r_busy <= 1'b0;
                end
                if (w_rdEn) begin
                    if (w_eLastX) begin
                        r_ex    <= '0;
                        r_ey    <= r_ey + DIM_W'(1);
                        r_eBank <= ~r_eBank;
                    end else begin
                        r_ex <= r_ex + DIM_W'(1);
                    end
                end
            end
        end
    end

    line_buffer #(
        .PIX_W (PIX_W),
        .AW    (DIM_W),
        .DEPTH (MAX_W)
    ) u_lineBuffer (
        .i_clk     (Clk),
        .i_nReset  (nReset),
        .i_wrEn    (w_hs),
        .i_wrBank  (r_fBank),
        .i_wrAddr  (r_fx),
        .i_wrData  (MemData),
        .i_setFull (w_hs && w_fLastX),
        .i_rdEn    (w_rdEn),
        .i_rdBank  (r_eBank),
        .i_rdAddr  (r_ex),
        .i_clrFull (w_clrFull),
        .o_rdData  (w_rdData),
        .o_full    (w_full)
    );

    assign MemReq   = (r_fState == F_FETCH);
    assign MemAddr  = r_addr;
    assign PixelOut = w_rdData;
    assign FrameOut = r_frameOut;
    assign LineOut  = r_lineOut;
    assign Busy     = r_busy;

endmodule

// File: tb/tb_frame_source.sv
// Directed bench for frame_source: a memory model whose data is a function of
// the address, a stream logger, and a reference check of each captured frame.
module tb_frame_source;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Start;
    logic [7:0]  Width, Height;
    logic [15:0] BaseAddr;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [7:0]  MemData;
    logic [7:0]  PixelOut;
    logic        FrameOut, LineOut, Busy;

    typedef struct {
        logic [7:0] pix;
        logic       fr;
        logic       ln;
        logic       busy;
    } sample_t;

    sample_t     log_q[$];
    logic [15:0] addr_q[$];
    int          nAsserts, nFails, nLineSeen, ackMode, stallLeft;
    bit          logEn, prevWait;
    logic [15:0] prevAddr;

    frame_source dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .Start    (Start),
        .Width    (Width),
        .Height   (Height),
        .BaseAddr (BaseAddr),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemAck   (MemAck),
        .MemData  (MemData),
        .PixelOut (PixelOut),
        .FrameOut (FrameOut),
        .LineOut  (LineOut),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] memVal(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign MemData = memVal(MemAddr);

    // Acknowledge pattern: 0 always, 1 random ~30%, 2 stall once mid line 1, 3 never
    always @(posedge Clk) begin
        #1;
        case (ackMode)
            0: MemAck = 1'b1;
            1: MemAck = ($urandom_range(99) < 30);
            2: begin
                if (addr_q.size() == 300 && stallLeft > 0) begin
                    MemAck = 1'b0;
                    stallLeft--;
                end else begin
                    MemAck = 1'b1;
                end
            end
            default: MemAck = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (logEn) begin
            if (prevWait && MemReq) begin
                checkOutput("addrHold", 32'(MemAddr), 32'(prevAddr));
            end
            prevWait = MemReq && !MemAck;
            prevAddr = MemAddr;
            if (MemReq && MemAck) addr_q.push_back(MemAddr);
            if (LineOut === 1'b1) nLineSeen++;
            log_q.push_back('{pix: PixelOut, fr: FrameOut, ln: LineOut, busy: Busy});
        end else begin
            prevWait = 1'b0;
        end
    end

    function automatic sample_t getS(input int i);
        sample_t s;
        s = '{pix: 'x, fr: 1'bx, ln: 1'bx, busy: 1'bx};
        if (i >= 0 && i < log_q.size()) s = log_q[i];
        return s;
    endfunction

    task automatic clearLogs();
        log_q.delete();
        addr_q.delete();
        nLineSeen = 0;
        logEn     = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] w, input logic [7:0] h, input logic [15:0] base,
                                 input logic expBusy);
        @(negedge Clk);
        Start    = 1'b1;
        Width    = w;
        Height   = h;
        BaseAddr = base;
        @(negedge Clk);
        Start = 1'b0;
        checkOutput("busyAfterStart", 32'(Busy), 32'(expBusy));
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < maxCycles) begin
            @(negedge Clk);
            n++;
        end
        checkOutput({tag, " idleInTime"}, 32'(Busy === 1'b0), 32'(1));
        repeat (3) @(negedge Clk);
        logEn = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input int w, input int h, input logic [15:0] base,
                              input int exactGap, input int minGap);
        int s, ls, idx, nFr, nLn, gap, maxGap;
        sample_t smp;
        logic [15:0] a;
        checkOutput({tag, " addrCount"}, 32'(addr_q.size()), 32'(w * h));
        for (int i = 0; i < addr_q.size() && i < w * h; i++) begin
            a = base + 16'(i);
            checkOutput({tag, " addr"}, 32'(addr_q[i]), 32'(a));
        end
        nFr = 0;
        nLn = 0;
        s   = -1;
        foreach (log_q[i]) begin
            if (log_q[i].fr === 1'b1) begin
                nFr++;
                if (s < 0) s = i;
            end
            if (log_q[i].ln === 1'b1) nLn++;
        end
        checkOutput({tag, " frameStrobes"}, 32'(nFr), 32'(1));
        checkOutput({tag, " lineStrobes"}, 32'(nLn), 32'(h - 1));
        if (s < 0) return;
        ls     = s;
        maxGap = 0;
        for (int y = 0; y < h; y++) begin
            if (y > 0) begin
                idx = ls + w;
                while (idx < log_q.size() && log_q[idx].ln !== 1'b1) begin
                    checkOutput({tag, " gapPixel"}, 32'(log_q[idx].pix), 32'(0));
                    idx++;
                end
                gap = idx - (ls + w);
                if (gap > maxGap) maxGap = gap;
                checkOutput({tag, " gapAtLeastOne"}, 32'(gap >= 1), 32'(1));
                if (exactGap > 0) checkOutput({tag, " gapExact"}, 32'(gap), 32'(exactGap));
                ls = idx;
            end
            for (int x = 0; x < w; x++) begin
                smp = getS(ls + x);
                a   = base + 16'(y * w + x);
                checkOutput({tag, " pixel"}, 32'(smp.pix), 32'(memVal(a)));
                checkOutput({tag, " strobes"}, 32'({smp.fr, smp.ln}),
                            32'({x == 0 && y == 0, x == 0 && y > 0}));
            end
        end
        smp = getS(ls + w - 1);
        checkOutput({tag, " busyOnLastPixel"}, 32'(smp.busy), 32'(1));
        smp = getS(ls + w);
        checkOutput({tag, " busyAfterLastPixel"}, 32'(smp.busy), 32'(0));
        if (minGap > 0) checkOutput({tag, " stallGap"}, 32'(maxGap >= minGap), 32'(1));
    endtask

    initial begin
        nAsserts  = 0;
        nFails    = 0;
        nLineSeen = 0;
        ackMode   = 0;
        stallLeft = 0;
        logEn     = 1'b0;
        prevWait  = 1'b0;
        prevAddr  = '0;
        MemAck    = 1'b0;
        nReset    = 1'b0;
        Start     = 1'b0;
        Width     = '0;
        Height    = '0;
        BaseAddr  = '0;

        repeat (3) @(negedge Clk);
        checkOutput("rst MemReq", 32'(MemReq), 32'(0));
        checkOutput("rst MemAddr", 32'(MemAddr), 32'(0));
        checkOutput("rst PixelOut", 32'(PixelOut), 32'(0));
        checkOutput("rst FrameOut", 32'(FrameOut), 32'(0));
        checkOutput("rst LineOut", 32'(LineOut), 32'(0));
        checkOutput("rst Busy", 32'(Busy), 32'(0));
        nReset = 1'b1;
        @(negedge Clk);

        $display("[TB] 4x3 frame, ack always high");
        ackMode = 0;
        clearLogs();
        applyStimulus(8'd4, 8'd3, 16'h0100, 1'b1);
        waitIdle("basic", 200);
        checkFrame("basic", 4, 3, 16'h0100, 1, 0);

        $display("[TB] 4x3 frame, random ack");
        ackMode = 1;
        clearLogs();
        applyStimulus(8'd4, 8'd3, 16'h0100, 1'b1);
        waitIdle("random", 1000);
        checkFrame("random", 4, 3, 16'h0100, 0, 0);

        $display("[TB] 1x1 frame");
        ackMode = 0;
        clearLogs();
        applyStimulus(8'd1, 8'd1, 16'h0040, 1'b1);
        waitIdle("oneByOne", 100);
        checkFrame("oneByOne", 1, 1, 16'h0040, 0, 0);

        $display("[TB] zero-size starts");
        applyStimulus(8'd0, 8'd3, 16'h0500, 1'b0);
        repeat (4) begin
            @(negedge Clk);
            checkOutput("zeroW Busy", 32'(Busy), 32'(0));
            checkOutput("zeroW MemReq", 32'(MemReq), 32'(0));
        end
        applyStimulus(8'd3, 8'd0, 16'h0500, 1'b0);
        @(negedge Clk);
        checkOutput("zeroH MemReq", 32'(MemReq), 32'(0));

        $display("[TB] address wrap with start while busy");
        clearLogs();
        applyStimulus(8'd4, 8'd2, 16'hFFFE, 1'b1);
        repeat (2) @(negedge Clk);
        applyStimulus(8'd2, 8'd2, 16'h3000, 1'b1);
        waitIdle("wrap", 200);
        checkFrame("wrap", 4, 2, 16'hFFFE, 1, 0);

        $display("[TB] reset during line 2");
        clearLogs();
        applyStimulus(8'd4, 8'd3, 16'h0100, 1'b1);
        begin
            int n;
            n = 0;
            while (nLineSeen < 2 && n < 200) begin
                @(negedge Clk);
                n++;
            end
            checkOutput("midReset line2Reached", 32'(nLineSeen), 32'(2));
        end
        nReset = 1'b0;
        @(negedge Clk);
        checkOutput("midReset MemReq", 32'(MemReq), 32'(0));
        checkOutput("midReset MemAddr", 32'(MemAddr), 32'(0));
        checkOutput("midReset PixelOut", 32'(PixelOut), 32'(0));
        checkOutput("midReset FrameOut", 32'(FrameOut), 32'(0));
        checkOutput("midReset LineOut", 32'(LineOut), 32'(0));
        checkOutput("midReset Busy", 32'(Busy), 32'(0));
        nReset = 1'b1;
        logEn  = 1'b0;
        @(negedge Clk);
        clearLogs();
        applyStimulus(8'd4, 8'd3, 16'h0200, 1'b1);
        waitIdle("afterReset", 200);
        checkFrame("afterReset", 4, 3, 16'h0200, 1, 0);

        $display("[TB] 200x2 frame with 50-cycle stall in line 1");
        ackMode   = 2;
        stallLeft = 50;
        clearLogs();
        applyStimulus(8'd200, 8'd2, 16'h1000, 1'b1);
        waitIdle("stall", 3000);
        checkFrame("stall", 200, 2, 16'h1000, 0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
